// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite movement scheduler.
//  - DIR_* : 3-bit direction codes produced by spriteMoveFSM (101..111 behave as DEFAULT)
//  - sched_state_t : scheduler FSM state encoding
// Build option: SPRITE_MOVE_WRAP_EN (consumed by sprite_axis_step) selects wrap vs clamp.
package sprite_pkg;

   localparam logic [2:0] DIR_DEFAULT = 3'b000;
   localparam logic [2:0] DIR_RIGHT   = 3'b001;
   localparam logic [2:0] DIR_DOWN    = 3'b010;
   localparam logic [2:0] DIR_UP      = 3'b011;
   localparam logic [2:0] DIR_LEFT    = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } sched_state_t;

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis position update: moves pos by STEP up (inc) or down (dec), kept inside 0..MAX.
// Default build clamps at the edges; with SPRITE_MOVE_WRAP_EN defined the axis wraps toroidally.
// Ports:
//  pos        in  W   current coordinate (assumed 0..MAX)
//  inc        in  1   move +STEP
//  dec        in  1   move -STEP (ignored when inc is set)
//  next_pos_c out W   combinational next coordinate
module sprite_axis_step #(
   parameter int unsigned W    = 10,
   parameter int unsigned MAX  = 639,
   parameter int unsigned STEP = 1
) (
   input  logic [W-1:0] pos,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] next_pos_c
);

   // One extra bit so pos+STEP cannot overflow before the edge test.
   localparam int unsigned EW = W + 1;

   logic [EW-1:0] sum_c;

   assign sum_c = EW'(pos) + EW'(STEP);

   // Edge handling for both directions.
   always_comb begin
      next_pos_c = pos;
      if (inc) begin
         if (sum_c > EW'(MAX)) begin
`ifdef SPRITE_MOVE_WRAP_EN
            next_pos_c = W'(sum_c - EW'(MAX + 1));
`else
            next_pos_c = W'(MAX);
`endif
         end else begin
            next_pos_c = W'(sum_c);
         end
      end else if (dec) begin
         if (EW'(pos) < EW'(STEP)) begin
`ifdef SPRITE_MOVE_WRAP_EN
            next_pos_c = W'(EW'(pos) + EW'(MAX + 1) - EW'(STEP));
`else
            next_pos_c = '0;
`endif
         end else begin
            next_pos_c = pos - W'(STEP);
         end
      end
   end

endmodule

// File: rtl/sprite_move_scheduler.sv
// Once per frame walks sprites 0..N_SPRITES-1, applies each direction code to the stored
// position and writes the new position to the sprite bank over a req/ack port.
// Build option: SPRITE_MOVE_WRAP_EN selects toroidal wrap instead of clamping (no port/timing change).
// Ports:
//  clk, reset     clock and synchronous active-high reset
//  frame_tick     one-cycle pulse starting a pass (ignored and flagged while busy)
//  dir_codes      sprite i direction code at [3i+2:3i]
//  wr_ack         bank accepts the write in a cycle with wr_req && wr_ack
//  wr_req/addr/x/y  registered write request to the sprite bank
//  busy           high from the cycle after an accepted tick through the done cycle
//  done           one-cycle pulse at pass completion
//  frame_overrun  sticky flag: tick seen while busy, cleared only by reset
module sprite_move_scheduler
   import sprite_pkg::*;
#(
   parameter int unsigned N_SPRITES = 4,
   parameter int unsigned IDX_W     = 2,
   parameter int unsigned X_W       = 10,
   parameter int unsigned Y_W       = 10,
   parameter int unsigned X_MAX     = 639,
   parameter int unsigned Y_MAX     = 479,
   parameter int unsigned STEP      = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   frame_tick,
   input  logic [3*N_SPRITES-1:0] dir_codes,
   input  logic                   wr_ack,
   output logic                   wr_req,
   output logic [IDX_W-1:0]       wr_addr,
   output logic [X_W-1:0]         wr_x,
   output logic [Y_W-1:0]         wr_y,
   output logic                   busy,
   output logic                   done,
   output logic                   frame_overrun
);

   sched_state_t     state;
   logic [IDX_W-1:0] idx;
   logic [X_W-1:0]   pos_x [N_SPRITES];
   logic [Y_W-1:0]   pos_y [N_SPRITES];

   logic [2:0]       code_c;
   logic [X_W-1:0]   next_x_c;
   logic [Y_W-1:0]   next_y_c;

   // Direction code of the sprite currently being serviced.
   always_comb begin
      code_c = DIR_DEFAULT;
      for (int i = 0; i < N_SPRITES; i++) begin
         if (idx == IDX_W'(i)) code_c = dir_codes[3*i +: 3];
      end
   end

   sprite_axis_step #(.W(X_W), .MAX(X_MAX), .STEP(STEP)) u_step_x (
      .pos        (pos_x[idx]),
      .inc        (code_c == DIR_RIGHT),
      .dec        (code_c == DIR_LEFT),
      .next_pos_c (next_x_c)
   );

   sprite_axis_step #(.W(Y_W), .MAX(Y_MAX), .STEP(STEP)) u_step_y (
      .pos        (pos_y[idx]),
      .inc        (code_c == DIR_DOWN),
      .dec        (code_c == DIR_UP),
      .next_pos_c (next_y_c)
   );

   // Scheduler FSM with registered outputs; reset also drops any tick in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         idx           <= '0;
         wr_req        <= 1'b0;
         wr_addr       <= '0;
         wr_x          <= '0;
         wr_y          <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         frame_overrun <= 1'b0;
         for (int i = 0; i < N_SPRITES; i++) begin
            pos_x[i] <= '0;
            pos_y[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         if (frame_tick && (state != S_IDLE)) frame_overrun <= 1'b1;
         case (state)
            S_IDLE: begin
               if (frame_tick) begin
                  state <= S_CALC;
                  idx   <= '0;
                  busy  <= 1'b1;
               end
            end
            S_CALC: begin
               pos_x[idx] <= next_x_c;
               pos_y[idx] <= next_y_c;
               wr_addr    <= idx;
               wr_x       <= next_x_c;
               wr_y       <= next_y_c;
               wr_req     <= 1'b1;
               state      <= S_WRITE;
            end
            S_WRITE: begin
               // wr_req is always high here, so wr_ack alone marks acceptance.
               if (wr_ack) begin
                  wr_req <= 1'b0;
                  if (idx == IDX_W'(N_SPRITES - 1)) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     idx   <= idx + IDX_W'(1);
                     state <= S_CALC;
                  end
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_move_scheduler.sv
// Self-checking bench for sprite_move_scheduler: directed scenarios plus random passes,
// checked against a per-sprite position model. Honours SPRITE_MOVE_WRAP_EN like the design.
module tb_sprite_move_scheduler;

   localparam int N     = 4;
   localparam int IDX_W = 2;
   localparam int X_W   = 10;
   localparam int Y_W   = 10;
   localparam int X_MAX = 639;
   localparam int Y_MAX = 479;
   localparam int STEP  = 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             frame_tick;
   logic [3*N-1:0]   dir_codes;
   logic             wr_ack;
   logic             wr_req;
   logic [IDX_W-1:0] wr_addr;
   logic [X_W-1:0]   wr_x;
   logic [Y_W-1:0]   wr_y;
   logic             busy;
   logic             done;
   logic             frame_overrun;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int mx [N];
   int my [N];
   int obs_x [N];
   int obs_y [N];
   int exp_ovr;
   int saved;

   sprite_move_scheduler dut (
      .clk           (clk),
      .reset         (reset),
      .frame_tick    (frame_tick),
      .dir_codes     (dir_codes),
      .wr_ack        (wr_ack),
      .wr_req        (wr_req),
      .wr_addr       (wr_addr),
      .wr_x          (wr_x),
      .wr_y          (wr_y),
      .busy          (busy),
      .done          (done),
      .frame_overrun (frame_overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: one axis moved by d (+1/-1/0) steps within 0..mx_.
   function automatic int axis(input int p, input int d, input int mx_);
      if (d > 0) begin
         if (p + STEP > mx_) begin
`ifdef SPRITE_MOVE_WRAP_EN
            return p + STEP - (mx_ + 1);
`else
            return mx_;
`endif
         end
         return p + STEP;
      end else if (d < 0) begin
         if (p < STEP) begin
`ifdef SPRITE_MOVE_WRAP_EN
            return p + (mx_ + 1) - STEP;
`else
            return 0;
`endif
         end
         return p - STEP;
      end
      return p;
   endfunction

   task automatic set_code(input int i, input logic [2:0] c);
      dir_codes[3*i +: 3] = c;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < N; i++) begin
         mx[i] = 0;
         my[i] = 0;
      end
      exp_ovr = 0;
   endtask

   // One full pass. gap: 0 = wr_ack tied high, >0 = fixed ack delay, <0 = random delay 0..3.
   // extra_tick pulses frame_tick while the pass is running.
   task automatic run_pass(input int gap, input bit extra_tick);
      int t0, w, g, ex, ey;
      logic [2:0] c;
      frame_tick = 1'b1;
      wr_ack     = (gap == 0);
      t0         = cyc;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      check("busy_rise", int'(busy), 1);
      for (int i = 0; i < N; i++) begin
         c  = dir_codes[3*i +: 3];
         ex = axis(mx[i], (c == 3'b001) ? 1 : (c == 3'b100) ? -1 : 0, X_MAX);
         ey = axis(my[i], (c == 3'b010) ? 1 : (c == 3'b011) ? -1 : 0, Y_MAX);
         mx[i] = ex;
         my[i] = ey;
         w = 0;
         while (wr_req !== 1'b1 && w < 16) begin
            @(posedge clk); #1;
            w++;
         end
         check("wr_req_wait", int'(wr_req), 1);
         if (wr_req !== 1'b1) return;
         if (gap == 0 && i == 0) check("first_req_latency", cyc - t0, 2);
         check("wr_addr", int'(wr_addr), i);
         check("wr_x", int'(wr_x), ex);
         check("wr_y", int'(wr_y), ey);
         obs_x[i] = int'(wr_x);
         obs_y[i] = int'(wr_y);
         if (gap != 0) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            for (int k = 0; k < g; k++) begin
               @(posedge clk); #1;
               check("hold_req", int'(wr_req), 1);
               check("hold_addr", int'(wr_addr), i);
               check("hold_x", int'(wr_x), ex);
               check("hold_y", int'(wr_y), ey);
            end
            wr_ack = 1'b1;
         end
         if (extra_tick && i == 1) begin
            frame_tick = 1'b1;
            exp_ovr    = 1;
         end
         @(posedge clk); #1;
         frame_tick = 1'b0;
         if (gap != 0) wr_ack = 1'b0;
         check("req_drop", int'(wr_req), 0);
      end
      check("done_pulse", int'(done), 1);
      check("busy_in_done", int'(busy), 1);
      if (gap == 0) check("done_latency", cyc - t0, 2 * N + 1);
      @(posedge clk); #1;
      wr_ack = 1'b0;
      check("done_clear", int'(done), 0);
      check("busy_fall", int'(busy), 0);
      check("overrun", int'(frame_overrun), exp_ovr);
   endtask

   initial begin
      reset      = 1'b1;
      frame_tick = 1'b0;
      wr_ack     = 1'b0;
      dir_codes  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_wr_req", int'(wr_req), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_overrun", int'(frame_overrun), 0);
      check("rst_wr_addr", int'(wr_addr), 0);
      check("rst_wr_x", int'(wr_x), 0);
      check("rst_wr_y", int'(wr_y), 0);
      do_reset();

      // All DEFAULT, ack tied high.
      run_pass(0, 1'b0);

      // Sprite0 RIGHT x3; sprite1 UP at y=0 stays put at the lower edge.
      set_code(0, 3'b001);
      set_code(1, 3'b011);
      repeat (3) run_pass(0, 1'b0);
      check("t2_s0_x", obs_x[0], 3);
      check("t2_s1_y", obs_y[1], 0);

      // Sprite2 driven to the right edge, then one more RIGHT; sprite1 pushed down the Y edge.
      do_reset();
      dir_codes = '0;
      set_code(2, 3'b001);
      set_code(1, 3'b010);
      repeat (639) run_pass(0, 1'b0);
      check("t3_s2_x_edge", obs_x[2], 639);
      run_pass(0, 1'b0);
`ifdef SPRITE_MOVE_WRAP_EN
      check("t3_s2_x_past_edge", obs_x[2], 0);
`else
      check("t3_s2_x_past_edge", obs_x[2], 639);
`endif

      // Bank stalls for 5 cycles on every write.
      set_code(3, 3'b100);
      run_pass(5, 1'b0);

      // Tick while busy: flagged, pass unaffected.
      run_pass(-1, 1'b1);
      check("t5_overrun_sticky", int'(frame_overrun), 1);

      // Reset in the middle of a write, with a coincident tick that must be dropped.
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      for (int w = 0; w < 16 && wr_req !== 1'b1; w++) begin
         @(posedge clk); #1;
      end
      check("t5_req_before_rst", int'(wr_req), 1);
      reset      = 1'b1;
      frame_tick = 1'b1;
      @(posedge clk); #1;
      reset      = 1'b0;
      frame_tick = 1'b0;
      check("t5_rst_req", int'(wr_req), 0);
      check("t5_rst_busy", int'(busy), 0);
      check("t5_rst_overrun", int'(frame_overrun), 0);
      @(posedge clk); #1;
      check("t5_tick_dropped", int'(busy), 0);
      for (int i = 0; i < N; i++) begin
         mx[i] = 0;
         my[i] = 0;
      end
      exp_ovr   = 0;
      dir_codes = '0;
      run_pass(0, 1'b0);
      check("t5_s2_x_cleared", obs_x[2], 0);

      // Reserved code 111 behaves as DEFAULT.
      set_code(3, 3'b001);
      run_pass(0, 1'b0);
      saved = mx[3];
      set_code(3, 3'b111);
      run_pass(-1, 1'b0);
      check("t6_s3_x_111", obs_x[3], 1);
      check("t6_s3_x_model", obs_x[3], saved);

      // Random codes (including 101..111) and random ack delays.
      for (int p = 0; p < 60; p++) begin
         dir_codes = (3 * N)'($urandom);
         run_pass(-1, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
